// File: rtl/seq_fsm_pkg.sv
// Shared definitions for the serial pattern detector: state sizing, overlap
// mode constants and the elaboration-time next-state table builder.
package seq_fsm_pkg;

  localparam int MAX_LEN     = 32'sd16;
  localparam int OVERLAP_OFF = 32'sd0;
  localparam int OVERLAP_ON  = 32'sd1;

  // Indexed as [matched prefix length][input bit] -> next matched prefix length.
  typedef logic [MAX_LEN:0][1:0][4:0] next_tbl_t;

  function automatic int state_width(input int len);
    if (len < 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(len + 32'sd1);
    end
  endfunction

  function automatic next_tbl_t build_next_table(input int len,
                                                 input logic [MAX_LEN-1:0] pat,
                                                 input int overlap);
    next_tbl_t tbl;
    int        hs;
    int        n;
    int        j;
    int        best;
    logic      ok;
    logic      hb;
    tbl = '0;
    for (int s = 32'sd0; s <= MAX_LEN; s++) begin
      for (int b = 32'sd0; b < 32'sd2; b++) begin
        if (s <= len) begin
          // A full match without overlap forgets its history before the new bit.
          if ((s == len) && (overlap == OVERLAP_OFF)) begin
            hs = 32'sd0;
          end else begin
            hs = s;
          end
          n    = hs + 32'sd1;
          best = 32'sd0;
          for (int k = 32'sd1; k <= MAX_LEN; k++) begin
            if ((k <= len) && (k <= n)) begin
              ok = 1'b1;
              for (int i = 32'sd0; i < MAX_LEN; i++) begin
                if (i < k) begin
                  j = n - k + i;
                  if (j < hs) begin
                    hb = pat[len - 32'sd1 - j];
                  end else begin
                    hb = 1'(b);
                  end
                  if (hb != pat[len - 32'sd1 - i]) begin
                    ok = 1'b0;
                  end else begin
                    ok = ok;
                  end
                end else begin
                  ok = ok;
                end
              end
              if (ok) begin
                best = k;
              end else begin
                best = best;
              end
            end else begin
              best = best;
            end
          end
          tbl[s][b] = 5'(best);
        end else begin
          tbl[s][b] = 5'd0;
        end
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset, synchronous clear and saturation at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Clear wins over a simultaneous increment; the count never wraps.
  always_ff @(posedge clk) begin
    if (areset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/seq_detect_fsm.sv
// Moore serial pattern detector: tracks the matched prefix length of PATTERN
// through a constant next-state table and counts completed matches.
module seq_detect_fsm
  import seq_fsm_pkg::*;
#(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter int                     OVERLAP     = 1,
  parameter int                     CNT_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 areset,
  input  logic                                 en,
  input  logic                                 in,
  input  logic                                 count_clr,
  output logic                                 out,
  output logic [state_width(PATTERN_LEN)-1:0]  state_o,
  output logic [CNT_W-1:0]                     match_count
);

  localparam int             SW       = state_width(PATTERN_LEN);
  localparam logic [SW-1:0]  FULL_S   = SW'(PATTERN_LEN);
  localparam next_tbl_t      NEXT_TBL = build_next_table(PATTERN_LEN, 16'(PATTERN), OVERLAP);

  logic [SW-1:0] state_r;
  logic [SW-1:0] next_state_s;
  logic [4:0]    tbl_idx_s;
  logic          out_r;
  logic          inc_s;

  assign tbl_idx_s = 5'(state_r);

  // Next-state lookup; a disabled cycle holds the matched prefix.
  always_comb begin
    next_state_s = state_r;
    inc_s        = 1'b0;
    if (en) begin
      next_state_s = SW'(NEXT_TBL[tbl_idx_s][in]);
      inc_s        = (next_state_s == FULL_S);
    end else begin
      next_state_s = state_r;
      inc_s        = 1'b0;
    end
  end

  // State and Moore flag registers; the flag is derived from the next state so it tracks state_r exactly.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_r <= '0;
      out_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      out_r   <= (next_state_s == FULL_S);
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk    (clk),
    .areset (areset),
    .inc    (inc_s),
    .clr    (count_clr),
    .count  (match_count)
  );

  assign out     = out_r;
  assign state_o = state_r;

endmodule
